// File: rtl/morse_keyer.sv
`timescale 1ns/1ps
// morse_keyer
//
// Sends one Morse character (up to five dot/dash symbols) or a word space
// for each accepted START request. Symbol timing is derived from a unit
// prescaler of UNIT_CYCLES clock cycles.
//
// Optional feature macro: MORSE_KEYER_TONE_EN adds a square-wave sidetone
// output (TONE) that runs only while KEY is high.
//
// Parameters
//   UNIT_CYCLES  clock cycles per Morse time unit (2..65535)
//   TONE_HALF    clock cycles per TONE half-period (1..65535, tone build only)
//
// Ports
//   CLK      in   system clock, rising edge
//   RST      in   asynchronous active-high reset
//   START    in   request to send one character (accepted only when idle)
//   PATTERN  in   [4:0] symbols, 0 = dot, 1 = dash, bit 0 sent first
//   LEN      in   [2:0] symbol count, 0 = word space, 6..7 clamp to 5
//   BUSY     out  character or space in progress
//   DONE     out  one-cycle pulse on the final cycle of a character/space
//   KEY      out  registered keying line, high during a mark
//   TONE     out  sidetone (MORSE_KEYER_TONE_EN only)
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | waiting for START
// MARK   | key down for one symbol (1 unit dot, 3 units dash)
// GAP    | 1 unit key up between symbols of the same character
// CGAP   | 3 units key up after the last symbol; DONE on its final cycle
// WGAP   | 7 units key up for a word space; DONE on its final cycle
module morse_keyer #(
    parameter int UNIT_CYCLES = 4,
    parameter int TONE_HALF   = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       START,
    input  logic [4:0] PATTERN,
    input  logic [2:0] LEN,
    output logic       BUSY,
    output logic       DONE,
    output logic       KEY
`ifdef MORSE_KEYER_TONE_EN
    ,
    output logic       TONE
`endif
);

    if (UNIT_CYCLES < 2 || UNIT_CYCLES > 65535) begin : g_bad_unit_cycles
        $error("morse_keyer: UNIT_CYCLES out of range 2..65535");
    end
    if (TONE_HALF < 1 || TONE_HALF > 65535) begin : g_bad_tone_half
        $error("morse_keyer: TONE_HALF out of range 1..65535");
    end

    localparam logic [15:0] PRE_LAST = 16'(UNIT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_MARK = 3'd1,
        S_GAP  = 3'd2,
        S_CGAP = 3'd3,
        S_WGAP = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pre_q,   pre_d;     // unit prescaler, counts up and wraps
    logic [2:0]  units_q, units_d;   // units remaining in this state after the current one
    logic [4:0]  pat_q,   pat_d;     // shifted right so bit 0 is always the current symbol
    logic [2:0]  sym_q,   sym_d;     // symbols remaining after the current one
    logic        key_q,   key_d;

    logic [2:0]  len_clamped;
    logic        unit_end;
    logic        last_unit;

    always_comb begin
        state_d     = state_q;
        pre_d       = pre_q;
        units_d     = units_q;
        pat_d       = pat_q;
        sym_d       = sym_q;
        len_clamped = (LEN > 3'd5) ? 3'd5 : LEN;
        unit_end    = (pre_q == PRE_LAST);
        last_unit   = unit_end && (units_q == 3'd0);

        if (state_q != S_IDLE) begin
            if (unit_end) begin
                pre_d = 16'd0;
                if (units_q != 3'd0) begin
                    units_d = units_q - 3'd1;
                end
            end else begin
                pre_d = pre_q + 16'd1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (START) begin
                    pre_d = 16'd0;
                    pat_d = PATTERN;
                    if (len_clamped == 3'd0) begin
                        state_d = S_WGAP;
                        units_d = 3'd6;
                        sym_d   = 3'd0;
                    end else begin
                        state_d = S_MARK;
                        units_d = PATTERN[0] ? 3'd2 : 3'd0;
                        sym_d   = len_clamped - 3'd1;
                    end
                end
            end
            S_MARK: begin
                if (last_unit) begin
                    if (sym_q == 3'd0) begin
                        state_d = S_CGAP;
                        units_d = 3'd2;
                    end else begin
                        state_d = S_GAP;
                        units_d = 3'd0;
                        sym_d   = sym_q - 3'd1;
                        pat_d   = {1'b0, pat_q[4:1]};
                    end
                end
            end
            S_GAP: begin
                if (last_unit) begin
                    state_d = S_MARK;
                    units_d = pat_q[0] ? 3'd2 : 3'd0;
                end
            end
            S_CGAP, S_WGAP: begin
                if (last_unit) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // KEY is registered from the next state so it tracks MARK exactly.
        key_d = (state_d == S_MARK);
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= S_IDLE;
            pre_q   <= 16'd0;
            units_q <= 3'd0;
            pat_q   <= 5'd0;
            sym_q   <= 3'd0;
            key_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            units_q <= units_d;
            pat_q   <= pat_d;
            sym_q   <= sym_d;
            key_q   <= key_d;
        end
    end

    assign BUSY = (state_q != S_IDLE);
    assign DONE = ((state_q == S_CGAP) || (state_q == S_WGAP)) && last_unit;
    assign KEY  = key_q;

`ifdef MORSE_KEYER_TONE_EN
    localparam logic [15:0] TONE_LAST = 16'(TONE_HALF - 1);

    logic [15:0] tone_cnt_q, tone_cnt_d;
    logic        tone_q,     tone_d;

    // Driven from key_d so TONE starts and stops on the same cycles as KEY.
    always_comb begin
        tone_cnt_d = 16'd0;
        tone_d     = 1'b0;
        if (key_d) begin
            if (tone_cnt_q == TONE_LAST) begin
                tone_cnt_d = 16'd0;
                tone_d     = ~tone_q;
            end else begin
                tone_cnt_d = tone_cnt_q + 16'd1;
                tone_d     = tone_q;
            end
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            tone_cnt_q <= 16'd0;
            tone_q     <= 1'b0;
        end else begin
            tone_cnt_q <= tone_cnt_d;
            tone_q     <= tone_d;
        end
    end

    assign TONE = tone_q;
`endif

endmodule

// File: tb/tb_morse_keyer.sv
`timescale 1ns/1ps
module tb_morse_keyer;

    localparam int U = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [4:0] pattern;
    logic [2:0] len;
    logic       busy;
    logic       done;
    logic       key;
`ifdef MORSE_KEYER_TONE_EN
    logic       tone;
`endif

    int errors = 0;
    int checks = 0;

    // Expected {KEY, BUSY, DONE} for each cycle after acceptance.
    logic [2:0] exp_q[$];

    typedef struct {
        string      name;
        logic [4:0] p;
        logic [2:0] l;
        int         busy_len;
        bit         noisy;
    } vec_t;

    vec_t vecs[7];

    morse_keyer #(.UNIT_CYCLES(U), .TONE_HALF(1)) dut (
        .CLK     (clk),
        .RST     (rst),
        .START   (start),
        .PATTERN (pattern),
        .LEN     (len),
        .BUSY    (busy),
        .DONE    (done),
        .KEY     (key)
`ifdef MORSE_KEYER_TONE_EN
        ,
        .TONE    (tone)
`endif
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check3(input string name, input logic [2:0] act, input logic [2:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: key/busy/done got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Waveform built directly from Morse timing rules.
    function automatic void build_model(input logic [4:0] p, input logic [2:0] l);
        int n;
        exp_q.delete();
        n = (l > 3'd5) ? 5 : int'(l);
        if (n == 0) begin
            for (int i = 0; i < 7 * U; i++) exp_q.push_back(3'b010);
        end else begin
            for (int s = 0; s < n; s++) begin
                for (int i = 0; i < (p[s] ? 3 : 1) * U; i++) exp_q.push_back(3'b110);
                if (s < n - 1)
                    for (int i = 0; i < U; i++) exp_q.push_back(3'b010);
            end
            for (int i = 0; i < 3 * U; i++) exp_q.push_back(3'b010);
        end
        exp_q[exp_q.size() - 1] = 3'b011;
    endfunction

    // Sends one character with a START pulse and checks every cycle up to and
    // including the first idle cycle. With noisy set, START/PATTERN/LEN are
    // scrambled while busy; all of it must be ignored.
    task automatic run_char(input string name, input logic [4:0] p, input logic [2:0] l,
                            input int busy_len, input bit noisy);
        int         nbusy;
        int         mark_pos;
        logic [2:0] e;
        build_model(p, l);
        pattern = p;
        len     = l;
        start   = 1'b1;
        step();
        nbusy    = 0;
        mark_pos = 0;
        for (int c = 0; c <= exp_q.size(); c++) begin
            e = (c < exp_q.size()) ? exp_q[c] : 3'b000;
            check3($sformatf("%s cycle %0d", name, c + 1), {key, busy, done}, e);
`ifdef MORSE_KEYER_TONE_EN
            if (e[2]) begin
                check_int($sformatf("%s tone cycle %0d", name, c + 1), int'(tone), (mark_pos % 2 == 0) ? 1 : 0);
                mark_pos++;
            end else begin
                check_int($sformatf("%s tone off cycle %0d", name, c + 1), int'(tone), 0);
                mark_pos = 0;
            end
`endif
            if (busy) nbusy++;
            if (c < exp_q.size() && noisy) begin
                start   = 1'($urandom_range(0, 1));
                pattern = 5'($urandom);
                len     = 3'($urandom);
            end else begin
                start = 1'b0;
            end
            step();
        end
        check_int($sformatf("%s busy length", name), nbusy, busy_len);
    endtask

    initial begin
        int k;
        vecs[0] = '{"E",        5'b00000, 3'd1, 16, 1'b0};
        vecs[1] = '{"A",        5'b00010, 3'd2, 32, 1'b0};
        vecs[2] = '{"space",    5'b10110, 3'd0, 28, 1'b0};
        vecs[3] = '{"len7 dots",5'b00000, 3'd7, 48, 1'b0};
        vecs[4] = '{"T",        5'b00001, 3'd1, 24, 1'b1};
        vecs[5] = '{"zero",     5'b11111, 3'd5, 88, 1'b1};
        vecs[6] = '{"len6",     5'b10101, 3'd6, 72, 1'b1};

        rst     = 1'b1;
        start   = 1'b0;
        pattern = 5'd0;
        len     = 3'd0;
        #12;
        check3("reset state", {key, busy, done}, 3'b000);
`ifdef MORSE_KEYER_TONE_EN
        check_int("reset tone", int'(tone), 0);
`endif
        @(negedge clk);
        rst = 1'b0;
        step();

        for (int i = 0; i < 7; i++)
            run_char(vecs[i].name, vecs[i].p, vecs[i].l, vecs[i].busy_len, vecs[i].noisy);

        // START held high: mid-character and DONE-cycle START ignored,
        // next character starts the cycle after BUSY falls.
        build_model(5'b00000, 3'd1);
        pattern = 5'b00000;
        len     = 3'd1;
        start   = 1'b1;
        step();
        for (int c = 0; c < 16; c++) begin
            check3($sformatf("held E cycle %0d", c + 1), {key, busy, done}, exp_q[c]);
            step();
        end
        check3("held idle gap", {key, busy, done}, 3'b000);
        step();
        check3("held second start", {key, busy, done}, 3'b110);
        start = 1'b0;
        k = 0;
        while (busy && k < 200) begin
            step();
            k++;
        end
        check_int("held second E length", k, 16);

        // START pulse only in the DONE cycle must be ignored.
        build_model(5'b00000, 3'd1);
        start = 1'b1;
        step();
        for (int c = 0; c < 16; c++) begin
            check3($sformatf("done-start E cycle %0d", c + 1), {key, busy, done}, exp_q[c]);
            start = (c == 15);
            step();
        end
        start = 1'b0;
        check3("done-start idle 1", {key, busy, done}, 3'b000);
        step();
        check3("done-start idle 2", {key, busy, done}, 3'b000);

        // Reset in the middle of the dash of 'A'.
        build_model(5'b00010, 3'd2);
        pattern = 5'b00010;
        len     = 3'd2;
        start   = 1'b1;
        step();
        start = 1'b0;
        for (int c = 0; c < 12; c++) begin
            check3($sformatf("A pre-reset cycle %0d", c + 1), {key, busy, done}, exp_q[c]);
            step();
        end
        check3("A in dash", {key, busy, done}, 3'b110);
        #2;
        rst = 1'b1;
        #1;
        check3("async reset", {key, busy, done}, 3'b000);
        step();
        check3("reset held", {key, busy, done}, 3'b000);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            check3($sformatf("post-reset idle %0d", c), {key, busy, done}, 3'b000);
        end
        run_char("E after reset", 5'b00000, 3'd1, 16, 1'b0);

        // Random characters against the model.
        for (int i = 0; i < 30; i++) begin
            logic [4:0] p;
            logic [2:0] l;
            p = 5'($urandom);
            l = 3'($urandom_range(0, 7));
            build_model(p, l);
            run_char($sformatf("rand%0d p=%b l=%0d", i, p, l), p, l, exp_q.size(), 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 3)) step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
